// File: rtl/ndn_pkg.sv
// Shared NDN egress definitions: packet geometry, FSM states and
// the metadata-driven length decode.
package ndn_pkg;

  localparam int META_INTEREST_BIT = 6;
  localparam int INTEREST_LEN      = 9;
  localparam int DATA_LEN          = 41;
  localparam int PREFIX_W          = 64;
  localparam int DATA_W            = 256;
  localparam int IDX_W             = 6;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    SEND,
    GAP
  } tx_state_t;

  function automatic logic [IDX_W-1:0] pkt_len(
    input logic [7:0] meta
  );
    return meta[META_INTEREST_BIT] ? IDX_W'(INTEREST_LEN)
                                   : IDX_W'(DATA_LEN);
  endfunction

endpackage

// File: rtl/spi_shift_master.sv
// Mode-0 byte shifter: MSB first, SCLK low then high per bit,
// MOSI advances on each falling edge.
module spi_shift_master #(
  parameter int CLK_DIV = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] din,
  output logic       sclk,
  output logic       mosi,
  output logic       byte_done
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic          active;
  logic [DW-1:0] div_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          div_end;

  assign div_end   = div_cnt == DW'(CLK_DIV - 1);
  assign byte_done = active && sclk && div_end && bit_cnt == 3'd7;
  assign mosi      = active & shreg[7];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active  <= 1'b0;
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (load) begin
      active  <= 1'b1;
      sclk    <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      shreg   <= din;
    end else if (active) begin
      if (div_end) begin
        div_cnt <= '0;
        sclk    <= ~sclk;
        if (sclk) begin
          shreg   <= {shreg[6:0], 1'b0};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7)
            active <= 1'b0;
        end
      end else begin
        div_cnt <= div_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_packet_tx.sv
// Egress stage: buffers one FIB packet and frames it out over SPI,
// reporting packets offered while one is still in flight.
module spi_packet_tx
  import ndn_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       FIB_to_SPI_data_flag,
  input  logic [7:0] data_FIB_to_SPI,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       spi_mosi,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_dropped
);

  localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

  tx_state_t        state, state_nx;
  logic [IDX_W-1:0] idx, len, last;
  logic [GW-1:0]    gap_cnt;
  logic [7:0]       pkt [DATA_LEN];
  logic [7:0]       load_byte;
  logic             byte_done, load, dropped;
  logic             cap_end, send_end, gap_end;

  assign last     = len - IDX_W'(1);
  assign cap_end  = state == CAPTURE && idx == last;
  assign send_end = state == SEND && byte_done && idx == last;
  assign gap_end  = state == GAP && gap_cnt == GW'(CS_GAP - 1);

  // Byte 0 goes out at SEND entry; later bytes chain on byte_done.
  assign load = cap_end ||
                (state == SEND && byte_done && idx != last);
  assign load_byte = cap_end ? pkt[0] : pkt[idx + IDX_W'(1)];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (FIB_to_SPI_data_flag) state_nx = CAPTURE;
      CAPTURE: if (cap_end)  state_nx = SEND;
      SEND:    if (send_end) state_nx = GAP;
      GAP:     if (gap_end)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    spi_cs_n = 1'b1;
    tx_busy  = 1'b1;
    tx_done  = 1'b0;
    unique case (state)
      IDLE:    tx_busy  = 1'b0;
      CAPTURE: ;
      SEND:    spi_cs_n = 1'b0;
      GAP:     tx_done  = gap_cnt == '0;
      default: ;
    endcase
  end

  assign tx_dropped = dropped;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx     <= '0;
      len     <= IDX_W'(DATA_LEN);
      gap_cnt <= '0;
      dropped <= 1'b0;
    end else begin
      dropped <= FIB_to_SPI_data_flag && state != IDLE;
      unique case (state)
        IDLE: begin
          idx     <= '0;
          gap_cnt <= '0;
        end
        CAPTURE: begin
          if (idx == '0) len <= pkt_len(data_FIB_to_SPI);
          idx <= cap_end ? '0 : idx + IDX_W'(1);
        end
        SEND:    if (byte_done) idx <= idx + IDX_W'(1);
        GAP:     gap_cnt <= gap_cnt + GW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == CAPTURE) pkt[idx] <= data_FIB_to_SPI;
  end

  spi_shift_master #(
    .CLK_DIV(CLK_DIV)
  ) u_shift (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .din       (load_byte),
    .sclk      (spi_sclk),
    .mosi      (spi_mosi),
    .byte_done (byte_done)
  );

endmodule

// File: doc/spi_packet_tx.md
# spi_packet_tx

Downstream stage of `fib_table` on the egress path: captures the byte stream that `fib_table` emits toward SPI (`FIB_to_SPI_data_flag` + `data_FIB_to_SPI`) into a one-packet buffer. It then serializes that packet off-chip as an SPI mode-0 master, MSB first, bytes in arrival order. It owns packet-length decode from the metadata byte, packet framing with chip-select, and drop reporting when the FIB offers a packet while a previous one is still in flight.

## Interface
- `CLK_DIV`, 2: SCLK half-period in `clk` cycles (≥1).
- `CS_GAP`, 4: idle `clk` cycles with `spi_cs_n` high between packets (≥1).
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `FIB_to_SPI_data_flag`  in  1  one-cycle start pulse from FIB.
- `data_FIB_to_SPI`  in  8  packet byte; byte k valid in cycle N+1+k after the flag in cycle N.
- `spi_sclk`  out  1  SPI clock, idles low.
- `spi_cs_n`  out  1  chip select, active-low.
- `spi_mosi`  out  1  serial data.
- `tx_busy`  out  1  high from flag acceptance through end of CS gap.
- `tx_done`  out  1  one-cycle pulse when `spi_cs_n` rises.
- `tx_dropped`  out  1  one-cycle pulse when a flag is ignored.

## Operation
- Reset values: `spi_sclk`=0, `spi_cs_n`=1, `spi_mosi`=0, `tx_busy`=0, `tx_done`=0, `tx_dropped`=0, state IDLE, counters 0.
- Packet layout: byte 0 metadata, bytes 1–8 prefix (MSB first), bytes 9–40 data (data packets only).
- Length decode: metadata bit 6 = 1 means interest, L=9; bit 6 = 0 means data, L=41 (0x70 → 9, 0x30 → 41).
- States:
  - IDLE: flag=1 → CAPTURE, `tx_busy`=1.
  - CAPTURE: stores one byte per cycle at index 0..L-1. L is latched from byte 0. After byte L-1 → SEND.
  - SEND: `spi_cs_n`=0. Shifts 8·L bits. After the last bit → GAP with `spi_cs_n`=1 and `tx_done` pulse.
  - GAP: counts `CS_GAP` cycles → IDLE, `tx_busy`=0.
- Flag asserted in CAPTURE, SEND or GAP: ignored, `tx_dropped` pulses the next cycle, and the in-flight packet is unaffected. A flag in the same cycle the FSM returns to IDLE is accepted.
- No backpressure toward the FIB exists; drop is the only overflow response.
- Reset asserted mid-operation: immediate return to reset values, with the packet discarded and `spi_cs_n` high asynchronously.

## Timing
- Flag in cycle N, L-byte packet: bytes captured at N+1..N+L; SEND entered at N+L+1, with `spi_cs_n` falling and `spi_mosi` = bit 7 of byte 0 in that cycle.
- SCLK: low for `CLK_DIV` cycles, then high for `CLK_DIV` cycles, per bit. The first rising edge is `CLK_DIV` cycles after `spi_cs_n` falls.
- MOSI changes only on SCLK falling edges, or at SEND entry for bit 0. It is stable across every rising edge.
- After the 8·L-th bit's high phase ends, SCLK returns low and `spi_cs_n` rises in the same cycle. `spi_cs_n` low duration is exactly 16·L·`CLK_DIV` cycles.
- `tx_done` is high in the cycle `spi_cs_n` rises. `tx_busy` falls `CS_GAP` cycles later.
- Bit counter width covers 8·41=328; byte index covers 0..40; no wrap within a packet.

## Structure
- Shared package `ndn_pkg`: `META_INTEREST_BIT`=6, `INTEREST_LEN`=9, `DATA_LEN`=41, `PREFIX_W`=64, `DATA_W`=256, and the state enum.
- Sub-module `spi_shift_master`: loads a byte, produces SCLK/MOSI for 8 bits per `CLK_DIV`, and signals byte-done. The top FSM and the 41×8 buffer stay in `spi_packet_tx`.

## Test plan
- Interest packet: flag + bytes 0x70, 00 00 FF FF 00 00 FF FF, `CLK_DIV`=2 → `spi_cs_n` low 288 cycles; sampling on SCLK rising edges recovers the 9 bytes exactly; one `tx_done`.
- Data packet: 0x30, prefix 0x0000FFFF0000FFFF, 32 bytes "this is an example" right-aligned zero-padded → 41 bytes recovered; `spi_cs_n` low 1312 cycles.
- Flag during SEND of an interest packet → one `tx_dropped` pulse; MOSI stream for the first packet unchanged; no second CS frame.
- Back-to-back packets: second flag at the cycle `tx_busy` falls → accepted; `spi_cs_n` high at least `CS_GAP`=4 cycles between frames.
- Reset asserted at bit 20 of SEND → `spi_cs_n`=1, `spi_sclk`=0, `tx_busy`=0 immediately; a subsequent interest packet transmits correctly.
- `CLK_DIV`=1 build: interest packet → `spi_cs_n` low 144 cycles, same recovered bytes.
